// File: rtl/cnt_down_timer_pkg.sv
// Shared types and constants for the mm:ss BCD countdown timer.
// State encodings, BCD digit limits and preset saturation helpers.
package cnt_down_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam logic [3:0] TENS_MAX  = 4'd5;
   localparam logic [3:0] UNITS_MAX = 4'd9;

   function automatic logic [3:0] sat_tens(input logic [3:0] d);
      return (d > TENS_MAX) ? TENS_MAX : d;
   endfunction

   function automatic logic [3:0] sat_units(input logic [3:0] d);
      return (d > UNITS_MAX) ? UNITS_MAX : d;
   endfunction

endpackage

// File: rtl/cnt_down_timer_cnt60_dn.sv
// One 00-59 BCD down counter stage with borrow out.
// Priority inside the stage: CLR > LD > DEC.
module cnt60_dn
   import cnt_down_timer_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       CLR,
   input  logic       LD,
   input  logic [3:0] DH,
   input  logic [3:0] DL,
   input  logic       DEC,
   output logic [3:0] QH,
   output logic [3:0] QL,
   output logic       BW
);

   logic [3:0] qh_q, qh_d;
   logic [3:0] ql_q, ql_d;

   always_comb begin
      qh_d = qh_q;
      ql_d = ql_q;
      if (CLR) begin
         qh_d = 4'd0;
         ql_d = 4'd0;
      end else if (LD) begin
         qh_d = DH;
         ql_d = DL;
      end else if (DEC) begin
         if (ql_q == 4'd0) begin
            ql_d = UNITS_MAX;
            qh_d = (qh_q == 4'd0) ? TENS_MAX : qh_q - 4'd1;
         end else begin
            ql_d = ql_q - 4'd1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         qh_q <= 4'd0;
         ql_q <= 4'd0;
      end else begin
         qh_q <= qh_d;
         ql_q <= ql_d;
      end
   end

   assign QH = qh_q;
   assign QL = ql_q;
   assign BW = (qh_q == 4'd0) && (ql_q == 4'd0) && DEC;

endmodule

// File: rtl/cnt_down_timer.sv
// mm:ss BCD countdown timer: load, run/pause on 1 Hz EN ticks,
// stop at 00:00, then DONE with a buzzer for BUZZ_TICKS ticks.
module cnt_down_timer
   import cnt_down_timer_pkg::*;
#(
   parameter int BUZZ_TICKS = 5
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CLR,
   input  logic       EN,
   input  logic       LOAD,
   input  logic       START,
   input  logic       PAUSE,
   input  logic [3:0] LD_MH,
   input  logic [3:0] LD_ML,
   input  logic [3:0] LD_SH,
   input  logic [3:0] LD_SL,
   output logic [3:0] MH,
   output logic [3:0] ML,
   output logic [3:0] SH,
   output logic [3:0] SL,
   output logic       DONE,
   output logic       BUZZ,
   output logic [1:0] STATE
);

   localparam logic [3:0] BUZZ_N = 4'(BUZZ_TICKS);

   state_e     state_q, state_d;
   logic [3:0] buzz_cnt_q, buzz_cnt_d;
   logic       buzz_q, buzz_d;
   logic       done_q, done_d;

   logic       load_ok;
   logic       dec_en;
   logic       sec_bw;
   logic       min_bw;
   logic       is_zero;
   logic       one_left;

   assign load_ok = LOAD && !CLR &&
                    ((state_q == ST_IDLE) || (state_q == ST_DONE));

   assign dec_en = (state_q == ST_RUN) && EN && !PAUSE && !CLR;

   cnt60_dn u_sec (
      .CLK (CLK),
      .RST (RST),
      .CLR (CLR),
      .LD  (load_ok),
      .DH  (sat_tens(LD_SH)),
      .DL  (sat_units(LD_SL)),
      .DEC (dec_en),
      .QH  (SH),
      .QL  (SL),
      .BW  (sec_bw)
   );

   cnt60_dn u_min (
      .CLK (CLK),
      .RST (RST),
      .CLR (CLR),
      .LD  (load_ok),
      .DH  (sat_tens(LD_MH)),
      .DL  (sat_units(LD_ML)),
      .DEC (sec_bw),
      .QH  (MH),
      .QL  (ML),
      .BW  (min_bw)
   );

   assign is_zero  = (MH == 4'd0) && (ML == 4'd0) &&
                     (SH == 4'd0) && (SL == 4'd0);
   assign one_left = (MH == 4'd0) && (ML == 4'd0) &&
                     (SH == 4'd0) && (SL == 4'd1);

   always_comb begin
      state_d    = state_q;
      buzz_cnt_d = buzz_cnt_q;
      buzz_d     = buzz_q;
      if (CLR || load_ok) begin
         state_d    = ST_IDLE;
         buzz_cnt_d = 4'd0;
         buzz_d     = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (!PAUSE && START && !is_zero)
                  state_d = ST_RUN;
            end
            ST_RUN: begin
               if (PAUSE) begin
                  state_d = ST_PAUSED;
               end else if (min_bw) begin
                  // Full underflow cannot occur from a nonzero RUN value.
                  state_d = ST_IDLE;
               end else if (EN && one_left) begin
                  state_d    = ST_DONE;
                  buzz_cnt_d = 4'd0;
                  buzz_d     = 1'b1;
               end
            end
            ST_PAUSED: begin
               if (!PAUSE && START)
                  state_d = ST_RUN;
            end
            ST_DONE: begin
               if (EN && (buzz_cnt_q < BUZZ_N)) begin
                  buzz_cnt_d = buzz_cnt_q + 4'd1;
                  buzz_d     = (buzz_cnt_q + 4'd1) < BUZZ_N;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         buzz_cnt_q <= 4'd0;
         buzz_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         buzz_cnt_q <= buzz_cnt_d;
         buzz_q     <= buzz_d;
         done_q     <= done_d;
      end
   end

   assign STATE = state_q;
   assign DONE  = done_q;
   assign BUZZ  = buzz_q;

endmodule

// File: tb/tb_cnt_down_timer.sv
// Directed bench for cnt_down_timer: count, borrow, pause,
// saturation, buzzer timing, async reset and priority cases.
module tb_cnt_down_timer;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       CLR = 1'b0;
   logic       EN = 1'b0;
   logic       LOAD = 1'b0;
   logic       START = 1'b0;
   logic       PAUSE = 1'b0;
   logic [3:0] LD_MH = '0, LD_ML = '0, LD_SH = '0, LD_SL = '0;
   logic [3:0] MH, ML, SH, SL;
   logic       DONE, BUZZ;
   logic [1:0] STATE;

   int total = 0;
   int bad = 0;

   wire [15:0] val = {MH, ML, SH, SL};

   cnt_down_timer #(.BUZZ_TICKS(5)) dut (
      .CLK(CLK), .RST(RST), .CLR(CLR), .EN(EN),
      .LOAD(LOAD), .START(START), .PAUSE(PAUSE),
      .LD_MH(LD_MH), .LD_ML(LD_ML), .LD_SH(LD_SH), .LD_SL(LD_SL),
      .MH(MH), .ML(ML), .SH(SH), .SL(SL),
      .DONE(DONE), .BUZZ(BUZZ), .STATE(STATE)
   );

   always #5 CLK = ~CLK;

   task automatic cyc(input logic en, ld, st, pa, cl);
      EN = en; LOAD = ld; START = st; PAUSE = pa; CLR = cl;
      @(negedge CLK);
      EN = 0; LOAD = 0; START = 0; PAUSE = 0; CLR = 0;
   endtask

   task automatic set_ld(input logic [15:0] v);
      {LD_MH, LD_ML, LD_SH, LD_SL} = v;
   endtask

   task automatic test_reset;
      total++;
      if ({val, DONE, BUZZ, STATE} !== 20'h0) begin
         bad++;
         $display("FAIL reset got=%h/%b%b/%0d exp=0000/00/0", val, DONE, BUZZ, STATE);
      end
   endtask

   task automatic test_minute_borrow;
      logic [15:0] exp_v [6] = '{16'h0104, 16'h0103, 16'h0102,
                                 16'h0101, 16'h0100, 16'h0059};
      set_ld(16'h0105);
      cyc(0, 1, 0, 0, 0);
      total++;
      if (val !== 16'h0105 || STATE !== 2'd0) begin
         bad++;
         $display("FAIL mb_load got=%h st=%0d exp=0105 st=0", val, STATE);
      end
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) begin
         cyc(1, 0, 0, 0, 0);
         total++;
         if (val !== exp_v[i] || STATE !== 2'd1) begin
            bad++;
            $display("FAIL mb_tick%0d got=%h st=%0d exp=%h st=1", i, val, STATE, exp_v[i]);
         end
      end
   endtask

   task automatic test_done_buzz;
      cyc(0, 0, 0, 0, 1);
      set_ld(16'h0002);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      total++;
      if (val !== 16'h0001 || DONE !== 1'b0 || BUZZ !== 1'b0) begin
         bad++;
         $display("FAIL db_one got=%h d=%b b=%b exp=0001 d=0 b=0", val, DONE, BUZZ);
      end
      cyc(1, 0, 0, 0, 0);
      total++;
      if (val !== 16'h0000 || DONE !== 1 || BUZZ !== 1 || STATE !== 2'd3) begin
         bad++;
         $display("FAIL db_term got=%h d=%b b=%b st=%0d exp=0000 d=1 b=1 st=3",
                  val, DONE, BUZZ, STATE);
      end
      for (int i = 1; i <= 6; i++) begin
         cyc(1, 0, 0, 0, 0);
         total++;
         if (BUZZ !== (i < 5) || DONE !== 1'b1 || val !== 16'h0) begin
            bad++;
            $display("FAIL db_buzz%0d got b=%b d=%b v=%h exp b=%b d=1 v=0000",
                     i, BUZZ, DONE, val, (i < 5));
         end
      end
   endtask

   task automatic test_pause;
      cyc(0, 0, 0, 0, 1);
      set_ld(16'h1000);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      total++;
      if (val !== 16'h0959) begin
         bad++;
         $display("FAIL pz_borrow got=%h exp=0959", val);
      end
      cyc(1, 0, 0, 1, 0);
      total++;
      if (val !== 16'h0959 || STATE !== 2'd2) begin
         bad++;
         $display("FAIL pz_pause got=%h st=%0d exp=0959 st=2", val, STATE);
      end
      repeat (3) cyc(1, 0, 0, 0, 0);
      total++;
      if (val !== 16'h0959 || STATE !== 2'd2) begin
         bad++;
         $display("FAIL pz_hold got=%h st=%0d exp=0959 st=2", val, STATE);
      end
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      total++;
      if (val !== 16'h0958 || STATE !== 2'd1) begin
         bad++;
         $display("FAIL pz_resume got=%h st=%0d exp=0958 st=1", val, STATE);
      end
   endtask

   task automatic test_load_rules;
      cyc(0, 0, 0, 0, 1);
      set_ld({4'd7, 4'd12, 4'd8, 4'd15});
      cyc(0, 1, 0, 0, 0);
      total++;
      if (val !== 16'h5959 || STATE !== 2'd0) begin
         bad++;
         $display("FAIL ld_sat got=%h st=%0d exp=5959 st=0", val, STATE);
      end
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0);
      total++;
      if (val !== 16'h0000 || STATE !== 2'd0) begin
         bad++;
         $display("FAIL ld_zero_start got=%h st=%0d exp=0000 st=0", val, STATE);
      end
      set_ld(16'h0003);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      set_ld(16'h4444);
      cyc(0, 1, 0, 0, 0);
      total++;
      if (val !== 16'h0002 || STATE !== 2'd1) begin
         bad++;
         $display("FAIL ld_in_run got=%h st=%0d exp=0002 st=1", val, STATE);
      end
      cyc(1, 0, 0, 0, 0);
      total++;
      if (val !== 16'h0001 || STATE !== 2'd1) begin
         bad++;
         $display("FAIL ld_continue got=%h st=%0d exp=0001 st=1", val, STATE);
      end
   endtask

   task automatic test_async_reset;
      cyc(0, 0, 0, 0, 1);
      set_ld(16'h0531);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      total++;
      if (val !== 16'h0530 || STATE !== 2'd1) begin
         bad++;
         $display("FAIL ar_pre got=%h st=%0d exp=0530 st=1", val, STATE);
      end
      #2 RST = 1'b1;
      #1;
      total++;
      if ({val, DONE, BUZZ, STATE} !== 20'h0) begin
         bad++;
         $display("FAIL ar_now got=%h/%b%b/%0d exp=0000/00/0", val, DONE, BUZZ, STATE);
      end
      @(negedge CLK);
      RST = 1'b0;
      cyc(1, 0, 0, 0, 0);
      total++;
      if (val !== 16'h0000 || STATE !== 2'd0) begin
         bad++;
         $display("FAIL ar_after got=%h st=%0d exp=0000 st=0", val, STATE);
      end
   endtask

   task automatic test_priority;
      set_ld(16'h0001);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      total++;
      if (STATE !== 2'd3 || DONE !== 1'b1) begin
         bad++;
         $display("FAIL pr_done got st=%0d d=%b exp st=3 d=1", STATE, DONE);
      end
      set_ld(16'h5959);
      cyc(0, 1, 0, 0, 1);
      total++;
      if ({val, DONE, BUZZ, STATE} !== 20'h0) begin
         bad++;
         $display("FAIL pr_clr_load got=%h/%b%b/%0d exp=0000/00/0", val, DONE, BUZZ, STATE);
      end
      set_ld(16'h0010);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 1, 1, 0);
      total++;
      if (val !== 16'h0009 || STATE !== 2'd2) begin
         bad++;
         $display("FAIL pr_start_pause got=%h st=%0d exp=0009 st=2", val, STATE);
      end
      cyc(1, 0, 0, 0, 0);
      total++;
      if (val !== 16'h0009) begin
         bad++;
         $display("FAIL pr_paused_en got=%h exp=0009", val);
      end
   endtask

   initial begin
      @(negedge CLK);
      test_reset;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      test_reset;
      test_minute_borrow;
      test_done_buzz;
      test_pause;
      test_load_rules;
      test_async_reset;
      test_priority;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
